turn_ctl: RTL



---
 rtl/game_pkg.sv | 19 +
 rtl/turn_timer.sv | 38 +++
 rtl/turn_ctl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the two-player throwing game.
// Holds the turn state enum, the link power width and player ids.
package game_pkg;

  localparam int POWER_W = 5;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    FLIGHT,
    RESOLVE,
    SWAP,
    OVER
  } turn_state_t;

endpackage

// File: rtl/turn_timer.sv
// Turn timeout counter: cleared by start, counts while run is high.
// Ports: clk, rst, start, run in; expire out on the last turn cycle.
module turn_timer #(
  parameter int TIMEOUT_CYCLES = 600000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = run && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turn_ctl.sv
// Game-flow sequencer: ready gating, turns, flight, damage, winner.
// Ports: clk, rst, player readies, throw/flight/new-game pulses in;
// active_player, throw_flag, power_out, hp1/hp2, game_over, winner out.
// TURN_TIMEOUT_EN adds a forced power-1 throw after TIMEOUT_CYCLES.
module turn_ctl
  import game_pkg::*;
#(
  parameter int HP_INIT        = 5,
  parameter int HP_W           = 3,
  parameter int POWER_STRONG   = 24,
  parameter int TIMEOUT_CYCLES = 600000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               player1_ready,
  input  logic               player2_ready,
  input  logic               throw_req,
  input  logic [POWER_W-1:0] power_in,
  input  logic               throw_done,
  input  logic               hit,
  input  logic               new_game,
  output logic               active_player,
  output logic               throw_flag,
  output logic [POWER_W-1:0] power_out,
  output logic [HP_W-1:0]    hp1,
  output logic [HP_W-1:0]    hp2,
  output logic               game_over,
  output logic               winner
);

  localparam logic [HP_W-1:0] HP_FULL = HP_W'(HP_INIT);

  turn_state_t state_q, state_d;
  logic               active_q, active_d;
  logic               flag_q, flag_d;
  logic [POWER_W-1:0] power_q, power_d;
  logic [HP_W-1:0]    hp1_q, hp1_d;
  logic [HP_W-1:0]    hp2_q, hp2_d;
  logic               go_q, go_d;
  logic               win_q, win_d;
  logic               hit_q, hit_d;

  logic               expire;
  logic               fire;
  logic [POWER_W-1:0] fire_pow;
  logic [HP_W-1:0]    dmg;
  logic [HP_W-1:0]    hp_opp;
  logic [HP_W-1:0]    hp_new;

`ifdef TURN_TIMEOUT_EN
  logic timer_start;
  assign timer_start = (state_d == TURN) && (state_q != TURN);

  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .run   (state_q == TURN),
    .expire(expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign expire = 1'b0;
`endif

  // a real request wins over the timeout; zero power still flies
  assign fire = throw_req || expire;
  always_comb begin
    fire_pow = throw_req ? power_in : POWER_W'(1);
    if (fire_pow == '0) fire_pow = POWER_W'(1);
  end

  assign dmg    = (power_q >= POWER_W'(POWER_STRONG)) ? HP_W'(2) : HP_W'(1);
  assign hp_opp = (active_q == P1) ? hp2_q : hp1_q;
  always_comb begin
    hp_new = hp_opp;
    if (hit_q) hp_new = (hp_opp > dmg) ? hp_opp - dmg : '0;
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    flag_d   = flag_q;
    power_d  = power_q;
    hp1_d    = hp1_q;
    hp2_d    = hp2_q;
    go_d     = go_q;
    win_d    = win_q;
    hit_d    = hit_q;
    unique case (state_q)
      IDLE: begin
        if (player1_ready && player2_ready) state_d = TURN;
      end
      TURN: begin
        if (fire) begin
          power_d = fire_pow;
          flag_d  = 1'b1;
          state_d = FLIGHT;
        end
      end
      FLIGHT: begin
        if (throw_done) begin
          hit_d   = hit;
          flag_d  = 1'b0;
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (active_q == P1) hp2_d = hp_new;
        else                hp1_d = hp_new;
        if (hp_new == '0) begin
          go_d    = 1'b1;
          win_d   = active_q;
          power_d = '0;
          state_d = OVER;
        end else begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        active_d = ~active_q;
        state_d  = TURN;
      end
      OVER: begin
        if (new_game) begin
          hp1_d    = HP_FULL;
          hp2_d    = HP_FULL;
          active_d = P1;
          go_d     = 1'b0;
          win_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      active_q <= P1;
      flag_q   <= 1'b0;
      power_q  <= '0;
      hp1_q    <= HP_FULL;
      hp2_q    <= HP_FULL;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      flag_q   <= flag_d;
      power_q  <= power_d;
      hp1_q    <= hp1_d;
      hp2_q    <= hp2_d;
      go_q     <= go_d;
      win_q    <= win_d;
      hit_q    <= hit_d;
    end
  end

  assign active_player = active_q;
  assign throw_flag    = flag_q;
  assign power_out     = power_q;
  assign hp1           = hp1_q;
  assign hp2           = hp2_q;
  assign game_over     = go_q;
  assign winner        = win_q;

endmodule
